// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// default IM address width and frame field widths.
package mips_pkg;

  localparam int IM_ADDR_WIDTH = 10;
  localparam int LEN_W         = 16;
  localparam int CSUM_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IM write port of the loader, bundled as one interface.
// The loader uses the slave view; the stream source / IM side uses master.
interface imem_loader_if import mips_pkg::*; #(
  parameter int ADDR_WIDTH = IM_ADDR_WIDTH
) ();

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader: parses a length/words/XOR-checksum byte
// frame, writes each word into IM and keeps the CPU held until a good load.
module imem_loader import mips_pkg::*; #(
  parameter int ADDR_WIDTH = IM_ADDR_WIDTH,
  parameter int BASE_ADDR  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  imem_loader_if.slave bus,
  output logic         o_cpu_hold,
  output logic         o_done,
  output logic         o_err
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           CAPACITY = 32'd1 << ADDR_WIDTH;

  state_t                r_state, w_state_next;
  logic [LEN_W-1:0]      r_words, w_words_next;
  logic [1:0]            r_bidx, w_bidx_next;
  logic [23:0]           r_asm, w_asm_next;
  logic [CSUM_W-1:0]     r_xor, w_xor_next;
  logic                  r_im_we, w_im_we_next;
  logic [ADDR_WIDTH-1:0] r_im_addr, w_im_addr_next;
  logic [31:0]           r_im_wdata, w_im_wdata_next;
  logic                  r_cpu_hold;
  logic                  r_done, w_done_next;
  logic                  r_err, w_err_next;
  logic                  w_xfer;
  logic [LEN_W-1:0]      w_len;

  assign bus.in_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_xfer       = bus.in_valid && bus.in_ready;
  // r_words holds the high length byte until the low byte completes it.
  assign w_len        = {r_words[LEN_W-1:8], bus.in_data};

  assign bus.im_we    = r_im_we;
  assign bus.im_addr  = r_im_addr;
  assign bus.im_wdata = r_im_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_words    <= '0;
      r_bidx     <= '0;
      r_asm      <= '0;
      r_xor      <= '0;
      r_im_we    <= 1'b0;
      r_im_addr  <= BASE;
      r_im_wdata <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_words    <= w_words_next;
      r_bidx     <= w_bidx_next;
      r_asm      <= w_asm_next;
      r_xor      <= w_xor_next;
      r_im_we    <= w_im_we_next;
      r_im_addr  <= w_im_addr_next;
      r_im_wdata <= w_im_wdata_next;
      r_cpu_hold <= (w_state_next != S_DONE);
      r_done     <= w_done_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_words_next    = r_words;
    w_bidx_next     = r_bidx;
    w_asm_next      = r_asm;
    w_xor_next      = r_xor;
    w_im_we_next    = 1'b0;
    // The address advances in the cycle its write strobe is visible.
    w_im_addr_next  = r_im_we ? r_im_addr + ADDR_WIDTH'(1) : r_im_addr;
    w_im_wdata_next = r_im_wdata;
    w_done_next     = r_done;
    w_err_next      = r_err;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_state_next   = S_LEN_HI;
          w_done_next    = 1'b0;
          w_err_next     = 1'b0;
          w_xor_next     = '0;
          w_bidx_next    = '0;
          w_words_next   = '0;
          w_im_addr_next = BASE;
        end
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          w_words_next = {bus.in_data, r_words[7:0]};
          w_xor_next   = r_xor ^ bus.in_data;
          w_state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          w_words_next = w_len;
          w_xor_next   = r_xor ^ bus.in_data;
          if (w_len == '0) begin
            w_state_next = S_CSUM;
          end else if (32'(w_len) > CAPACITY) begin
            w_state_next = S_ERR;
            w_err_next   = 1'b1;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_xor_next  = r_xor ^ bus.in_data;
          w_asm_next  = {r_asm[15:0], bus.in_data};
          w_bidx_next = r_bidx + 2'd1;
          if (r_bidx == 2'd3) begin
            w_im_we_next    = 1'b1;
            w_im_wdata_next = {r_asm, bus.in_data};
            w_words_next    = r_words - LEN_W'(1);
            if (r_words == LEN_W'(1)) w_state_next = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (w_xfer) begin
          if (bus.in_data == r_xor) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_ERR;
            w_err_next   = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
